interleaver_crc_framer: RTL
===========================

// Module: interleaver_crc_framer
// PURPOSE
// - Upstream stage of the turbo interleaver FSM. Takes a bit-serial transport block and appends
//   CRC-24A. Emits the framed block as crc_start/crc_data/crc_end plus block_size to the interleaver.
// - Framed length K is K_SMALL (block_size=0) or K_LARGE (block_size=1).
// - Payload is K-24 bits, followed by 24 parity bits, MSB first.
// PARAMETERS
// K_SMALL   1056          framed length for block_size=0 (payload 1032 bits)
// K_LARGE   6144          framed length for block_size=1 (payload 6120 bits)
// CRC_W     24            CRC width
// CRC_POLY  24'h864CFB    CRC-24A generator, x^24 term implicit
// CNT_W     13            bit-counter width, must hold K_LARGE-1
// PORTS
// clk         in   1  rising-edge clock
// reset       in   1  asynchronous, active-low reset
// in_start    in   1  first payload bit strobe; sampled only in IDLE together with in_valid
// in_valid    in   1  in_data valid this cycle; accepted only when in_valid && in_ready
// in_data     in   1  payload bit
// in_bsize    in   1  block-size select, sampled with the accepted in_start bit
// in_ready    out  1  framer accepts payload bits this cycle
// block_size  out  1  latched in_bsize, held from crc_start through crc_end
// crc_valid   out  1  crc_data valid this cycle
// crc_start   out  1  one-cycle pulse with first framed bit
// crc_data    out  1  framed bit (payload, then parity)
// crc_end     out  1  one-cycle pulse with K-th (last) framed bit
// busy        out  1  high from accepted in_start until the cycle after crc_end
// BEHAVIOUR
// Reset (reset=0, async)
// - All outputs are 0, except in_ready=1. State is IDLE, the counter is 0 and the CRC register is 0.
// - Reset mid-block aborts the block: no crc_end is produced and the partial frame is discarded.
// States
// - IDLE: in_ready=1.
//   - On in_valid&&in_start: latch in_bsize, load cnt=1, register bit, update CRC, go to DATA.
//   - in_valid without in_start is dropped.
// - DATA: in_ready=1.
//   - Each accepted bit increments cnt and updates CRC.
//   - When the (K-24)-th payload bit is accepted, go to PARITY.
//   - in_start is ignored in DATA and treated as ordinary data.
// - PARITY: in_ready=0.
//   - Shift out CRC[23] one bit per cycle, unconditionally, for 24 consecutive cycles.
//   - After the 24th bit, go to IDLE.
// CRC
// - Galois LFSR with init 0, no final XOR, no reflection.
// - Per bit: fb = crc[23]^in_data; crc = {crc[22:0],1'b0} ^ (fb ? CRC_POLY : 0).
// Output timing
// - Outputs are registered with latency 1.
// - A bit accepted at cycle n appears on crc_data/crc_valid at cycle n+1.
// - crc_valid is low in cycles after in_valid=0 gaps in DATA; the stream stalls without loss.
// - The first parity bit appears the cycle after the last payload bit is output. No gap.
// - crc_start coincides with crc_valid of framed bit 0.
// - crc_end coincides with crc_valid of framed bit K-1 (the last parity bit).
// - block_size is stable while busy=1 and keeps its value in IDLE until the next in_start.
// Back-to-back blocks
// - in_start is accepted on the cycle PARITY returns to IDLE (in_ready=1).
// - The new crc_start may then follow crc_end by one cycle.
// Counter
// - Never wraps; cleared on in_start.
// - in_bsize changes mid-block have no effect.
// TESTING
// 1. block_size=0, 1032 zero payload bits, in_valid held high.
//    -> 1056 valid bits, all zero; crc_start at output bit 0; crc_end at bit 1055;
//       in_ready low exactly 24 cycles.
// 2. block_size=0, payload all 0 except last bit=1.
//    -> parity bits = 24'h864CFB MSB first; crc_end on final parity bit.
// 3. block_size=1, 6120 random bits with random in_valid gaps.
//    -> 6144 valid outputs; parity matches reference model; block_size=1 throughout;
//       no bit lost or duplicated.
// 4. Two blocks back-to-back, second in_start on the first cycle in_ready returns high.
//    -> second crc_start is one cycle after first crc_end; second CRC is independent (register was cleared).
// 5. Drive reset low at payload bit 500.
//    -> outputs clear asynchronously; in_ready=1; no crc_end.
//    -> A following 1032-bit zero block frames correctly.
// 6. in_valid with in_start=0 in IDLE, then in_start high during DATA.
//    -> IDLE bits dropped (crc_valid stays 0); mid-block in_start treated as data, no restart.

Source files
------------

// File: rtl/interleaver_crc_framer_if.sv
// Bit-serial payload stream in, framed bit stream out, between the source and the CRC framer.
interface interleaver_crc_framer_if;
    logic in_start;
    logic in_valid;
    logic in_data;
    logic in_bsize;
    logic in_ready;
    logic block_size;
    logic crc_valid;
    logic crc_start;
    logic crc_data;
    logic crc_end;
    logic busy;

    modport slave (
        input  in_start, in_valid, in_data, in_bsize,
        output in_ready, block_size, crc_valid, crc_start, crc_data, crc_end, busy
    );

    modport master (
        output in_start, in_valid, in_data, in_bsize,
        input  in_ready, block_size, crc_valid, crc_start, crc_data, crc_end, busy
    );
endinterface

// File: rtl/interleaver_crc_framer.sv
// Appends CRC-24A to a bit-serial transport block and frames it (start/data/end) for the
// turbo interleaver. Framed length is K_SMALL or K_LARGE selected by in_bsize at in_start.
module interleaver_crc_framer #(
    parameter int unsigned K_SMALL  = 1056,
    parameter int unsigned K_LARGE  = 6144,
    parameter int unsigned CRC_W    = 24,
    parameter logic [CRC_W-1:0] CRC_POLY = 24'h864CFB,
    parameter int unsigned CNT_W    = 13
) (
    input  logic                         clk,
    input  logic                         reset,
    interleaver_crc_framer_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PAY_LAST_SMALL   = CNT_W'(K_SMALL - CRC_W - 1);
    localparam logic [CNT_W-1:0] PAY_LAST_LARGE   = CNT_W'(K_LARGE - CRC_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST_SMALL = CNT_W'(K_SMALL - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST_LARGE = CNT_W'(K_LARGE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               bsize_q, bsize_d;
    logic               valid_q, valid_d;
    logic               data_q, data_d;
    logic               start_q, start_d;
    logic               end_q, end_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   pay_last_c;
    logic [CNT_W-1:0]   frame_last_c;

    // One step of the Galois CRC-24A LFSR (init 0, no reflection, no final XOR).
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    endfunction

    assign pay_last_c   = bsize_q ? PAY_LAST_LARGE   : PAY_LAST_SMALL;
    assign frame_last_c = bsize_q ? FRAME_LAST_LARGE : FRAME_LAST_SMALL;

    // Next-state and next-output logic; cnt holds the number of framed bits issued so far.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        bsize_d = bsize_q;
        valid_d = 1'b0;
        data_d  = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_start) begin
                    bsize_d = bus.in_bsize;
                    cnt_d   = CNT_W'(1);
                    crc_d   = crc_step({CRC_W{1'b0}}, bus.in_data);
                    valid_d = 1'b1;
                    data_d  = bus.in_data;
                    start_d = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.in_valid) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    crc_d   = crc_step(crc_q, bus.in_data);
                    valid_d = 1'b1;
                    data_d  = bus.in_data;
                    if (cnt_q == pay_last_c) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                valid_d = 1'b1;
                data_d  = crc_q[CRC_W-1];
                crc_d   = {crc_q[CRC_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == frame_last_c) begin
                    end_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != PARITY);
        busy_d  = (state_d != IDLE) || end_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= '0;
            bsize_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            bsize_q <= bsize_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            start_q <= start_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.block_size = bsize_q;
    assign bus.crc_valid  = valid_q;
    assign bus.crc_start  = start_q;
    assign bus.crc_data   = data_q;
    assign bus.crc_end    = end_q;
    assign bus.busy       = busy_q;

endmodule
